// File: rtl/mini_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mini_alu_pkg
//  Description : Opcodes, FSM state encoding and instruction field-slice
//                helpers shared by the mini_alu_core_p execution core.
//  Revision    : 1.0 - initial release
// ============================================================================
package mini_alu_pkg;

    // Opcode values; compared against an OPC_W-wide field after a width cast
    localparam int OP_NOP  = 0;
    localparam int OP_ADD  = 1;
    localparam int OP_SUB  = 2;
    localparam int OP_AND  = 3;
    localparam int OP_OR   = 4;
    localparam int OP_SHL  = 5;
    localparam int OP_SHR  = 6;
    localparam int OP_BLE  = 7;
    localparam int OP_BEQ  = 8;
    localparam int OP_JMP  = 9;
    localparam int OP_CALL = 10;
    localparam int OP_RET  = 11;
    localparam int OP_LED  = 12;
    localparam int OP_STO  = 13;
    localparam int OP_WVM  = 14;
    localparam int OP_HALT = 15;

    // Upper bounds for the generic slicing helpers
    localparam int INSTR_MAX_W = 128;
    localparam int FIELD_MAX_W = 32;

    typedef enum logic [0:0] {
        STATE_RUN    = 1'b0,
        STATE_HALTED = 1'b1
    } state_e;

    // Extract WIDTH bits starting at LSB from an instruction word
    function automatic logic [FIELD_MAX_W-1:0] slice_field(
        input logic [INSTR_MAX_W-1:0] instr,
        input int                     lsb,
        input int                     width
    );
        logic [INSTR_MAX_W-1:0] shifted;
        shifted = instr >> lsb;
        return shifted[FIELD_MAX_W-1:0] & ({FIELD_MAX_W{1'b1}} >> (FIELD_MAX_W - width));
    endfunction

    // Instruction layout (LSB first): src0 | src1 | dest | opcode
    function automatic logic [FIELD_MAX_W-1:0] src0_field(
        input logic [INSTR_MAX_W-1:0] instr, input int addr_w);
        return slice_field(instr, 0, addr_w);
    endfunction

    function automatic logic [FIELD_MAX_W-1:0] src1_field(
        input logic [INSTR_MAX_W-1:0] instr, input int addr_w);
        return slice_field(instr, addr_w, addr_w);
    endfunction

    function automatic logic [FIELD_MAX_W-1:0] dest_field(
        input logic [INSTR_MAX_W-1:0] instr, input int addr_w);
        return slice_field(instr, 2 * addr_w, addr_w);
    endfunction

    function automatic logic [FIELD_MAX_W-1:0] opc_field(
        input logic [INSTR_MAX_W-1:0] instr, input int addr_w, input int opc_w);
        return slice_field(instr, 3 * addr_w, opc_w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mini_alu_core_p_ret_stack.sv
`default_nettype none
// ============================================================================
//  Module      : ret_stack
//  Description : Parametrised LIFO holding return addresses. Push on full and
//                pop on empty are ignored; the caller flags those as faults.
//  Revision    : 1.0 - initial release
// ============================================================================
module ret_stack #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] top_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int SP_W = $clog2(DEPTH + 1);

    logic [SP_W-1:0]   sp_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    assign full_o  = (sp_q == SP_W'(DEPTH));
    assign empty_o = (sp_q == '0);

    // Stack pointer and storage update; a push writes the slot at sp
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_i && !full_o) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (sp_q == SP_W'(i)) begin
                    mem_q[i] <= data_i;
                end
            end
            sp_q <= sp_q + 1'b1;
        end else if (pop_i && !empty_o) begin
            sp_q <= sp_q - 1'b1;
        end
    end

    // Top-of-stack is the most recently pushed slot (sp-1)
    always_comb begin
        top_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sp_q == SP_W'(i + 1)) begin
                top_o = mem_q[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mini_alu_core_p.sv
`default_nettype none
// ============================================================================
//  Module      : mini_alu_core_p
//  Description : Two-stage (fetch / execute) micro-sequencer with one-level
//                result forwarding, call stack with fault detection and HALT.
//  Revision    : 1.0 - initial release
// ============================================================================
module mini_alu_core_p
    import mini_alu_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int IP_W        = 16,
    parameter int OPC_W       = 4,
    parameter int STACK_DEPTH = 4,
    parameter int SIGNED_CMP  = 0,
    parameter int VADDR_W     = 10,
    parameter int COLOR_W     = 3,
    localparam int INSTR_W    = OPC_W + 3 * ADDR_W
) (
    input  logic               Clock,
    input  logic               Reset,
    output logic [IP_W-1:0]    oIP,
    input  logic [INSTR_W-1:0] iInstruction,
    output logic [ADDR_W-1:0]  oReadAddr0,
    output logic [ADDR_W-1:0]  oReadAddr1,
    input  logic [DATA_W-1:0]  iReadData0,
    input  logic [DATA_W-1:0]  iReadData1,
    output logic               oWriteEnable,
    output logic [ADDR_W-1:0]  oWriteAddr,
    output logic [DATA_W-1:0]  oWriteData,
    output logic [7:0]         oLed,
    output logic               oVideoWrite,
    output logic [VADDR_W-1:0] oVideoAddr,
    output logic [COLOR_W-1:0] oVideoData,
    output logic               oStackFault,
    output logic               oHalted
);

    localparam int SH_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int CAT_W = (DATA_W > 2 * ADDR_W) ? DATA_W : 2 * ADDR_W;

    // Registered execute-stage state
    state_e            state_q;
    logic [IP_W-1:0]   ip_q;
    logic [IP_W-1:0]   ip_d;
    logic [OPC_W-1:0]  op_q;
    logic [ADDR_W-1:0] src0_q;
    logic [ADDR_W-1:0] src1_q;
    logic [ADDR_W-1:0] dest_q;
    logic              fwd_valid_q;
    logic [ADDR_W-1:0] fwd_addr_q;
    logic [DATA_W-1:0] fwd_data_q;
    logic [7:0]        led_q;
    logic              fault_q;

    // Fetch-side field decode
    logic [INSTR_MAX_W-1:0] w_instr_ext;
    logic [OPC_W-1:0]       w_opc_f;
    logic [ADDR_W-1:0]      w_src0_f;
    logic [ADDR_W-1:0]      w_src1_f;
    logic [ADDR_W-1:0]      w_dest_f;

    // Execute-side combinational results
    logic              w_run;
    logic              w_fwd0;
    logic              w_fwd1;
    logic [DATA_W-1:0] w_a0;
    logic [DATA_W-1:0] w_a1;
    logic              w_le;
    logic [CAT_W-1:0]  w_sto_wide;
    logic [DATA_W-1:0] w_result;
    logic              w_wr;
    logic              w_branch;
    logic [IP_W-1:0]   w_target;
    logic              w_push;
    logic              w_pop;
    logic              w_halt_evt;
    logic              w_fault_evt;
    logic              w_led_wr;
    logic              w_vid;
    logic              w_stop;
    logic [IP_W-1:0]   w_top;
    logic              w_full;
    logic              w_empty;

    assign w_instr_ext = INSTR_MAX_W'(iInstruction);
    assign w_opc_f     = OPC_W'(opc_field(w_instr_ext, ADDR_W, OPC_W));
    assign w_src0_f    = ADDR_W'(src0_field(w_instr_ext, ADDR_W));
    assign w_src1_f    = ADDR_W'(src1_field(w_instr_ext, ADDR_W));
    assign w_dest_f    = ADDR_W'(dest_field(w_instr_ext, ADDR_W));

    assign oReadAddr0  = w_src0_f;
    assign oReadAddr1  = w_src1_f;

    ret_stack #(
        .DATA_W (IP_W),
        .DEPTH  (STACK_DEPTH)
    ) u_ret_stack (
        .clk     (Clock),
        .rst     (Reset),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .data_i  (ip_q),
        .top_o   (w_top),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    // Operand selection: RAM data, or last cycle's result when it targeted the same register
    always_comb begin
        w_run      = (state_q == STATE_RUN);
        w_fwd0     = fwd_valid_q && (fwd_addr_q == src0_q) && (op_q != OPC_W'(OP_STO));
        w_fwd1     = fwd_valid_q && (fwd_addr_q == src1_q) && (op_q != OPC_W'(OP_STO));
        w_a0       = w_fwd0 ? fwd_data_q : iReadData0;
        w_a1       = w_fwd1 ? fwd_data_q : iReadData1;
        w_sto_wide = CAT_W'({src1_q, src0_q});
        if (SIGNED_CMP != 0) begin
            w_le = ($signed(w_a1) <= $signed(w_a0));
        end else begin
            w_le = (w_a1 <= w_a0);
        end
    end

    // Execute decode: ALU result, strobes, branch and stack control
    always_comb begin
        w_result    = '0;
        w_wr        = 1'b0;
        w_branch    = 1'b0;
        w_target    = IP_W'(dest_q);
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_halt_evt  = 1'b0;
        w_fault_evt = 1'b0;
        w_led_wr    = 1'b0;
        w_vid       = 1'b0;
        if (w_run) begin
            case (op_q)
                OPC_W'(OP_ADD): begin w_result = w_a1 + w_a0; w_wr = 1'b1; end
                OPC_W'(OP_SUB): begin w_result = w_a1 - w_a0; w_wr = 1'b1; end
                OPC_W'(OP_AND): begin w_result = w_a1 & w_a0; w_wr = 1'b1; end
                OPC_W'(OP_OR):  begin w_result = w_a1 | w_a0; w_wr = 1'b1; end
                OPC_W'(OP_SHL): begin w_result = w_a1 << w_a0[SH_W-1:0]; w_wr = 1'b1; end
                OPC_W'(OP_SHR): begin w_result = w_a1 >> w_a0[SH_W-1:0]; w_wr = 1'b1; end
                OPC_W'(OP_BLE): w_branch = w_le;
                OPC_W'(OP_BEQ): w_branch = (w_a1 == w_a0);
                OPC_W'(OP_JMP): w_branch = 1'b1;
                OPC_W'(OP_CALL): begin
                    if (w_full) begin
                        w_fault_evt = 1'b1;
                    end else begin
                        w_push   = 1'b1;
                        w_branch = 1'b1;
                    end
                end
                OPC_W'(OP_RET): begin
                    w_target = w_top;
                    if (w_empty) begin
                        w_fault_evt = 1'b1;
                    end else begin
                        w_pop    = 1'b1;
                        w_branch = 1'b1;
                    end
                end
                OPC_W'(OP_LED):  w_led_wr = 1'b1;
                OPC_W'(OP_STO):  begin w_result = w_sto_wide[DATA_W-1:0]; w_wr = 1'b1; end
                OPC_W'(OP_WVM):  w_vid = 1'b1;
                OPC_W'(OP_HALT): w_halt_evt = 1'b1;
                default: ;
            endcase
        end
        // No further fetch once halted or when this cycle halts the core
        w_stop = !w_run || w_halt_evt || w_fault_evt;
        oIP    = w_branch ? w_target : ip_q;
        ip_d   = w_stop ? ip_q : oIP + 1'b1;
    end

    assign oWriteEnable = w_wr;
    assign oWriteAddr   = dest_q;
    assign oWriteData   = w_result;
    assign oVideoWrite  = w_vid;
    assign oVideoAddr   = VADDR_W'(w_a0);
    assign oVideoData   = COLOR_W'(w_a1);
    assign oLed         = led_q;
    assign oStackFault  = fault_q;
    assign oHalted      = (state_q == STATE_HALTED);

    // Pipeline registers, forwarding record, LED/fault registers and RUN/HALTED FSM
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= STATE_RUN;
            ip_q        <= '0;
            op_q        <= OPC_W'(OP_NOP);
            src0_q      <= '0;
            src1_q      <= '0;
            dest_q      <= '0;
            fwd_valid_q <= 1'b0;
            fwd_addr_q  <= '0;
            fwd_data_q  <= '0;
            led_q       <= '0;
            fault_q     <= 1'b0;
        end else begin
            ip_q        <= ip_d;
            op_q        <= w_stop ? OPC_W'(OP_NOP) : w_opc_f;
            src0_q      <= w_src0_f;
            src1_q      <= w_src1_f;
            dest_q      <= w_dest_f;
            fwd_valid_q <= w_wr;
            fwd_addr_q  <= dest_q;
            fwd_data_q  <= w_result;
            if (w_led_wr) begin
                led_q <= 8'(w_a1);
            end
            if (w_fault_evt) begin
                fault_q <= 1'b1;
            end
            case (state_q)
                STATE_RUN: begin
                    if (w_halt_evt || w_fault_evt) begin
                        state_q <= STATE_HALTED;
                    end
                end
                default: state_q <= STATE_HALTED;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mini_alu_core_p.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mini_alu_core_p
//  Description : Directed-vector bench for mini_alu_core_p. Instance A uses
//                unsigned BLE, instance B signed BLE; both share one ROM.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mini_alu_core_p;
    import mini_alu_pkg::*;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 8;
    localparam int IP_W    = 16;
    localparam int INSTR_W = 28;
    localparam int VADDR_W = 10;
    localparam int COLOR_W = 3;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    always #5 Clock = ~Clock;

    logic [INSTR_W-1:0] rom [0:255];

    // Instance A signals
    logic [IP_W-1:0]    ip_a;
    logic [INSTR_W-1:0] instr_a;
    logic [ADDR_W-1:0]  ra0_a, ra1_a, wa_a;
    logic [DATA_W-1:0]  rd0_a, rd1_a, wd_a;
    logic               we_a, vw_a, sf_a, hl_a;
    logic [7:0]         led_a;
    logic [VADDR_W-1:0] va_a;
    logic [COLOR_W-1:0] vd_a;
    logic [DATA_W-1:0]  ram_a [0:255];

    // Instance B signals
    logic [IP_W-1:0]    ip_b;
    logic [INSTR_W-1:0] instr_b;
    logic [ADDR_W-1:0]  ra0_b, ra1_b, wa_b;
    logic [DATA_W-1:0]  rd0_b, rd1_b, wd_b;
    logic               we_b, vw_b, sf_b, hl_b;
    logic [7:0]         led_b;
    logic [VADDR_W-1:0] va_b;
    logic [COLOR_W-1:0] vd_b;
    logic [DATA_W-1:0]  ram_b [0:255];

    assign instr_a = rom[ip_a[7:0]];
    assign instr_b = rom[ip_b[7:0]];

    // Synchronous-read data RAMs (read returns the pre-write contents)
    always @(posedge Clock) begin
        rd0_a <= ram_a[ra0_a];
        rd1_a <= ram_a[ra1_a];
        if (we_a) ram_a[wa_a] <= wd_a;
        rd0_b <= ram_b[ra0_b];
        rd1_b <= ram_b[ra1_b];
        if (we_b) ram_b[wa_b] <= wd_b;
    end

    mini_alu_core_p #(.SIGNED_CMP(0)) u_dut_a (
        .Clock(Clock), .Reset(Reset), .oIP(ip_a), .iInstruction(instr_a),
        .oReadAddr0(ra0_a), .oReadAddr1(ra1_a), .iReadData0(rd0_a), .iReadData1(rd1_a),
        .oWriteEnable(we_a), .oWriteAddr(wa_a), .oWriteData(wd_a), .oLed(led_a),
        .oVideoWrite(vw_a), .oVideoAddr(va_a), .oVideoData(vd_a),
        .oStackFault(sf_a), .oHalted(hl_a)
    );

    mini_alu_core_p #(.SIGNED_CMP(1)) u_dut_b (
        .Clock(Clock), .Reset(Reset), .oIP(ip_b), .iInstruction(instr_b),
        .oReadAddr0(ra0_b), .oReadAddr1(ra1_b), .iReadData0(rd0_b), .iReadData1(rd1_b),
        .oWriteEnable(we_b), .oWriteAddr(wa_b), .oWriteData(wd_b), .oLed(led_b),
        .oVideoWrite(vw_b), .oVideoAddr(va_b), .oVideoData(vd_b),
        .oStackFault(sf_b), .oHalted(hl_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [INSTR_W-1:0] enc(input int op, input int d, input int s1, input int s0);
        return {4'(op), 8'(d), 8'(s1), 8'(s0)};
    endfunction

    task automatic step();
        @(negedge Clock);
    endtask

    task automatic begin_scn();
        Reset = 1'b1;
        for (int i = 0; i < 256; i++) rom[i] = '0;
    endtask

    // Leaves the bench at the negedge just after reset release (cycle 0)
    task automatic release_rst();
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // ---- Scenario 1: reset, forwarding, BLE, LED, WVM, CALL/RET, HALT ----
        begin_scn();
        rom[0]  = enc(OP_STO, 1, 0, 5);
        rom[1]  = enc(OP_STO, 2, 0, 7);
        rom[2]  = enc(OP_ADD, 3, 2, 1);
        rom[3]  = enc(OP_STO, 4, 0, 3);
        rom[4]  = enc(OP_BLE, 20, 4, 4);
        rom[5]  = enc(OP_LED, 0, 4, 0);
        rom[20] = enc(OP_LED, 0, 3, 0);
        rom[21] = enc(OP_STO, 5, 8'h03, 8'hFF);
        rom[22] = enc(OP_STO, 6, 0, 5);
        rom[23] = enc(OP_WVM, 0, 6, 5);
        rom[24] = enc(OP_CALL, 30, 0, 0);
        rom[25] = enc(OP_HALT, 0, 0, 0);
        rom[30] = enc(OP_LED, 0, 6, 0);
        rom[31] = enc(OP_RET, 0, 0, 0);
        release_rst();
        check_eq("rst_ip", 32'(ip_a), 0);
        check_eq("rst_led", 32'(led_a), 0);
        check_eq("rst_halted", 32'(hl_a), 0);
        check_eq("rst_fault", 32'(sf_a), 0);
        check_eq("rst_strobes", {30'd0, we_a, vw_a}, 0);
        step(); // c1: STO r1,5
        check_eq("sto1_we", 32'(we_a), 1);
        check_eq("sto1_wa", 32'(wa_a), 1);
        check_eq("sto1_wd", 32'(wd_a), 5);
        step(); // c2: STO r2,7
        check_eq("sto2_wd", 32'(wd_a), 7);
        step(); // c3: ADD r3 = r2 + r1
        check_eq("fwd_add_we", 32'(we_a), 1);
        check_eq("fwd_add_wa", 32'(wa_a), 3);
        check_eq("fwd_add_wd", 32'(wd_a), 12);
        step(); // c4: STO r4,3
        step(); // c5: BLE 3<=3 taken
        check_eq("ble_taken_ip", 32'(ip_a), 20);
        step(); // c6: LED r3 at 20
        check_eq("ble_next_ip", 32'(ip_a), 21);
        check_eq("skip5_led", 32'(led_a), 0);
        step(); // c7
        check_eq("led_val", 32'(led_a), 12);
        step(); // c8
        step(); // c9: WVM
        check_eq("wvm_strobe", 32'(vw_a), 1);
        check_eq("wvm_addr", 32'(va_a), 32'h3FF);
        check_eq("wvm_data", 32'(vd_a), 5);
        step(); // c10: CALL 30
        check_eq("wvm_pulse_end", 32'(vw_a), 0);
        check_eq("call_ip", 32'(ip_a), 30);
        step(); // c11: LED r6
        step(); // c12: RET
        check_eq("call_led", 32'(led_a), 5);
        check_eq("ret_ip", 32'(ip_a), 25);
        step(); // c13: HALT executing
        check_eq("halt_exec_ip", 32'(ip_a), 26);
        check_eq("halt_exec_flag", 32'(hl_a), 0);
        step(); // c14
        check_eq("halted_flag", 32'(hl_a), 1);
        check_eq("halted_nofault", 32'(sf_a), 0);
        step(); step();
        check_eq("halted_ip_frozen", 32'(ip_a), 26);

        // ---- Scenario 2: nested calls up to depth, then overflow ----
        begin_scn();
        rom[0]  = enc(OP_CALL, 10, 0, 0);
        rom[10] = enc(OP_CALL, 20, 0, 0);
        rom[20] = enc(OP_CALL, 30, 0, 0);
        rom[30] = enc(OP_CALL, 40, 0, 0);
        rom[40] = enc(OP_CALL, 50, 0, 0);
        release_rst();
        step(); step(); step(); step(); // c4: fourth CALL executing
        check_eq("nest4_ip", 32'(ip_a), 40);
        step(); // c5: overflow CALL
        check_eq("ovf_no_branch_ip", 32'(ip_a), 41);
        check_eq("ovf_fault_pre", 32'(sf_a), 0);
        step(); // c6
        check_eq("ovf_fault", 32'(sf_a), 1);
        check_eq("ovf_halted", 32'(hl_a), 1);
        check_eq("ovf_ip", 32'(ip_a), 41);
        step(); step();
        check_eq("ovf_ip_frozen", 32'(ip_a), 41);

        // ---- Scenario 3: RET on empty stack ----
        begin_scn();
        rom[0] = enc(OP_RET, 0, 0, 0);
        rom[1] = enc(OP_LED, 0, 3, 0);
        rom[2] = enc(OP_STO, 1, 0, 9);
        rom[3] = enc(OP_WVM, 0, 6, 5);
        release_rst();
        step(); // c1: RET, empty
        check_eq("uflow_ip", 32'(ip_a), 1);
        step(); // c2
        check_eq("uflow_fault", 32'(sf_a), 1);
        check_eq("uflow_halted", 32'(hl_a), 1);
        for (int i = 0; i < 5; i++) begin
            check_eq("uflow_no_strobe", {30'd0, we_a, vw_a}, 0);
            step();
        end
        check_eq("uflow_led_held", 32'(led_a), 0);

        // ---- Scenario 4: signed/unsigned BLE, shifts, SUB/AND/OR, BEQ ----
        begin_scn();
        rom[0]  = enc(OP_STO, 1, 0, 1);
        rom[1]  = enc(OP_STO, 2, 8'hFF, 8'hFF);
        rom[2]  = enc(OP_BLE, 40, 2, 1);
        rom[3]  = enc(OP_STO, 7, 0, 17);
        rom[4]  = enc(OP_SHL, 8, 1, 7);
        rom[5]  = enc(OP_SHR, 9, 2, 7);
        rom[6]  = enc(OP_SUB, 10, 1, 2);
        rom[7]  = enc(OP_AND, 11, 2, 7);
        rom[8]  = enc(OP_OR, 12, 1, 10);
        rom[9]  = enc(OP_BEQ, 50, 1, 1);
        rom[40] = enc(OP_HALT, 0, 0, 0);
        rom[50] = enc(OP_HALT, 0, 0, 0);
        release_rst();
        step(); step(); step(); // c3: BLE 0xFFFF <= 1
        check_eq("ble_unsigned_ip", 32'(ip_a), 3);
        check_eq("ble_signed_ip", 32'(ip_b), 40);
        step(); // c4
        step(); // c5: SHL
        check_eq("shl_wd", 32'(wd_a), 2);
        check_eq("shl_wa", 32'(wa_a), 8);
        check_eq("signed_halted", 32'(hl_b), 1);
        step(); // c6: SHR
        check_eq("shr_wd", 32'(wd_a), 32'h7FFF);
        step(); // c7: SUB
        check_eq("sub_wd", 32'(wd_a), 2);
        step(); // c8: AND
        check_eq("and_wd", 32'(wd_a), 32'h11);
        step(); // c9: OR
        check_eq("or_wd", 32'(wd_a), 3);
        step(); // c10: BEQ taken
        check_eq("beq_ip", 32'(ip_a), 50);

        // ---- Scenario 5: reset during a CALL clears the stack ----
        begin_scn();
        rom[0]  = enc(OP_CALL, 30, 0, 0);
        rom[30] = enc(OP_CALL, 40, 0, 0);
        release_rst();
        step(); // c1: CALL executing
        check_eq("call_pre_rst_ip", 32'(ip_a), 30);
        Reset   = 1'b1;
        rom[0]  = enc(OP_RET, 0, 0, 0);
        rom[30] = '0;
        step();
        check_eq("mid_rst_ip", 32'(ip_a), 0);
        Reset = 1'b0;
        step(); // c1: RET must see an empty stack
        check_eq("mid_rst_ret_ip", 32'(ip_a), 1);
        step();
        check_eq("mid_rst_stack_empty", 32'(sf_a), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mini_alu_core_p.md
Name: mini_alu_core_p

Overview:
Parametrised successor to the MiniAlu execution core: a two-stage (fetch / execute) pipelined micro-sequencer.
- Fetches from an external instruction ROM and reads/writes an external dual-read-port data RAM with synchronous read.
- Drives the LED register and the video-memory write port.
- Generalised in data width, return-address stack depth and video geometry.
- Adds AND/OR/shift/BEQ ops, a multi-entry call stack with fault detection, and a HALT state.

Parameters:
DATA_W, 16, datapath and RAM word width
ADDR_W, 8, data-RAM address width; also branch-target field width
IP_W, 16, instruction-pointer width
OPC_W, 4, opcode width; instruction width INSTR_W = OPC_W + 3*ADDR_W
STACK_DEPTH, 4, return-address stack entries (>=1)
SIGNED_CMP, 0, 1 = BLE compares two's-complement
VADDR_W, 10, video-memory address width
COLOR_W, 3, video pixel width

Ports:
Clock  in  1  system clock, posedge
Reset  in  1  synchronous, active-high
oIP  out  IP_W  ROM address (combinational)
iInstruction  in  INSTR_W  ROM data, same cycle as oIP
oReadAddr0  out  ADDR_W  = iInstruction[ADDR_W-1:0]
oReadAddr1  out  ADDR_W  = iInstruction[2*ADDR_W-1:ADDR_W]
iReadData0/iReadData1  in  DATA_W  RAM data, valid one cycle after address
oWriteEnable  out  1  RAM write strobe
oWriteAddr  out  ADDR_W  RAM write address
oWriteData  out  DATA_W  RAM write data
oLed  out  8  LED register
oVideoWrite  out  1  video-memory write strobe
oVideoAddr  out  VADDR_W  video write address
oVideoData  out  COLOR_W  video write pixel
oStackFault  out  1  sticky call-stack overflow/underflow
oHalted  out  1  core is in HALTED

Behaviour:
Reset values:
- ip_reg=0; decoded op=NOP; stack pointer=0; forwarding valid=0; state=RUN.
- oLed=0, oStackFault=0, oHalted=0; all strobes 0.
- Reset asserted mid-operation discards the in-flight instruction at the next edge.

Fetch:
- oIP = branch_taken ? target : ip_reg.
- Next ip_reg = oIP+1, so there is no delay slot and no squash.
- Execute latency is one cycle after fetch.

Execute:
- Opcode, src0, src1 and dest fields are registered.
- Operands come from iReadData0/1 unless forwarded.
- Forwarding: if the previous cycle wrote dest == src field and the current op is not STO, use the previous result. This applies per operand.

Opcodes (package constants):
- NOP=0.
- ADD=1, SUB=2, AND=3, OR=4: dest = src1 op src0, mod 2^DATA_W.
- SHL=5, SHR=6: dest = src1 shifted by src0[$clog2(DATA_W)-1:0], zero fill.
- BLE=7: branch if src1<=src0 (signedness per SIGNED_CMP).
- BEQ=8: branch if src1==src0.
- JMP=9.
- CALL=10, RET=11.
- LED=12: oLed <= src1[7:0] at the edge.
- STO=13: dest = {src1field,src0field}, zero-extended or truncated to DATA_W.
- WVM=14: oVideoWrite=1, addr=src0[VADDR_W-1:0], data=src1[COLOR_W-1:0].
- HALT=15.

Branch target:
- Target = dest field zero-extended to IP_W.
- For RET, target = top of stack.

Call stack:
- CALL pushes ip_reg (call address+1) and branches.
- CALL with stack full: no push, no branch, oStackFault<=1, state->HALTED.
- RET pops and branches.
- RET with stack empty: no branch, oStackFault<=1, state->HALTED.

State machine:
- RUN -> HALTED on HALT or a stack fault.
- HALTED -> RUN only via Reset.
- HALTED: oIP frozen at ip_reg, no strobes, oLed held, oHalted=1.

Decomposition:
- Package mini_alu_pkg holds the opcode localparams, the field-slice helpers and the STATE_RUN/STATE_HALTED encoding.
- Sub-module ret_stack (parametrised LIFO) provides push, pop, top, full and empty outputs, with a synchronous reset.

Test Plan:
1. STO r1,5; STO r2,7; ADD r3,r2,r1 back-to-back -> forwarding gives RAM[3]=12 with no stall; oWriteData=12 at the third execute cycle.
2. BLE with src1=3, src0=3 at address 4, target 20 -> oIP=20 in the same cycle, then 21; the instruction at address 5 is never executed.
3. CALL 30 at address 8 -> RET at 30 returns to 9. Nest STACK_DEPTH calls OK; one more CALL -> oStackFault=1, oHalted=1, oIP frozen.
4. RET after reset with an empty stack -> fault, halt, no RAM/video/LED strobes afterwards.
5. SIGNED_CMP=1: BLE with src1=16'hFFFF, src0=1 is taken; with SIGNED_CMP=0 it is not taken. SHL 1 by 17 shifts by 1 -> 2.
6. WVM src0=0x3FF, src1=5 -> oVideoWrite pulse for 1 cycle, oVideoAddr=0x3FF, oVideoData=5. Reset during a subsequent CALL -> next cycle oIP=0 and the stack is empty.
